d8_text_mem_scan: RTL and testbench
===================================

Name: d8_text_mem_scan

Overview:
- Responder end of the core's text-memory interface (mem_a/mem_dw/mem_we/mem_dr).
- Stores the characters the CPU writes and returns read data on mem_dr.
- On request, streams the visible character grid in raster order to a downstream character generator over a valid/ready handshake.
- Sits between the d8 core and the display pipeline.

Parameters:
- ADDR_W, 12, CPU text address width (4096 cells)
- DATA_W, 8, character width
- COLS, 80, characters per row
- ROWS, 30, rows per frame (COLS*ROWS must be <= 2**ADDR_W)
- COL_W, 7, width of ch_col (>= clog2(COLS))
- ROW_W, 5, width of ch_row (>= clog2(ROWS))

Ports:
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-low
- mem_a  in  ADDR_W  CPU cell address
- mem_dw  in  DATA_W  CPU write data
- mem_we  in  1  CPU write strobe; writes mem_dw to mem_a at the edge
- mem_dr  out  DATA_W  CPU read data
- scan_start  in  1  one-cycle pulse requesting a frame scan
- scan_busy  out  1  high from scan accept until the last beat is accepted
- ch_valid  out  1  stream beat valid
- ch_ready  in  1  downstream accepts the beat
- ch_data  out  DATA_W  character code
- ch_col  out  COL_W  column of the beat
- ch_row  out  ROW_W  row of the beat
- ch_last  out  1  high on the final beat of the frame (col COLS-1, row ROWS-1)
- frame_cnt  out  8  count of completed frames

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (sys_rst=0):
  - Immediately clears mem_dr, scan_busy, ch_valid, ch_data, ch_col, ch_row, ch_last and frame_cnt to 0.
  - FSM goes to IDLE and the scan address goes to 0.
  - RAM contents are not reset.
- CPU port:
  - mem_dr is registered: mem_dr = RAM[mem_a] as sampled at the edge, so 1-cycle latency.
  - Read-before-write: a write and read to the same address in one cycle returns the old data.
  - The CPU port is always served; the scan never stalls it.
- Scan port: a second RAM read port, also with 1-cycle latency.
- FSM states:
  - IDLE: scan_busy=0, ch_valid=0. scan_start=1 -> RD with addr=0, col=0, row=0; scan_busy=1 from the next cycle.
  - RD: issues a read at addr, then -> OUT next cycle. On entry to OUT, ch_data/ch_col/ch_row/ch_last are loaded and ch_valid=1.
  - OUT: all beat outputs are held stable while ch_ready=0.
    - On ch_valid & ch_ready with ch_last=0: addr+1; col+1, or on col==COLS-1 set col=0 and row+1; -> RD.
    - On ch_valid & ch_ready with ch_last=1: -> IDLE; frame_cnt+1 (wraps 255->0); scan_busy=0 next cycle.
- Throughput is one beat per 2 cycles at most; ch_valid drops for the RD cycle between beats.
- scan_start is ignored when not in IDLE, including the cycle in which the last beat is accepted.
- A CPU write to the scan address in the same cycle as RD: the scan gets the old value. A later write does not alter a beat already in OUT.
- addr is a linear counter kept in lockstep with col/row; no multiply in RTL.
- Address range is 0..COLS*ROWS-1 only; cells above are CPU-only scratch.

Decomposition:
- Package d8_text_pkg holds:
  - default COLS/ROWS/ADDR_W/DATA_W constants;
  - FSM state encoding (IDLE=2'd0, RD=2'd1, OUT=2'd2);
  - derived TEXT_CELLS = COLS*ROWS.
- Sub-module d8_text_ram:
  - inferred 2**ADDR_W x DATA_W RAM;
  - write/read port A (CPU), read-only port B (scan);
  - both reads registered, read-first.
- The FSM and counters stay in d8_text_mem_scan.

Test Plan:
- Reset: hold sys_rst=0 mid-activity -> every output 0 without waiting for a clock edge; after release, scan_busy=0 and frame_cnt=0.
- CPU access:
  - write 0x41 @0x005, then read 0x005 -> mem_dr=0x41 one cycle later;
  - same-cycle write 0x42 + read @0x005 -> mem_dr=0x41, next read gives 0x42.
- Full scan (COLS=4, ROWS=2): cells 0..7 = 0x10..0x17, pulse scan_start, ch_ready=1 ->
  - 8 beats with data 0x10..0x17;
  - (col,row) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1);
  - ch_last only on beat 8;
  - frame_cnt=1; scan_busy low 17 cycles after the start pulse.
- Backpressure: ch_ready=0 for 5 cycles while beat 3 is valid -> ch_data stays 0x12 with ch_valid=1 and col=2; no beat lost or duplicated.
- Ignored starts: scan_start during beat 2, and coincident with last-beat acceptance -> exactly one frame, frame_cnt increments by 1, FSM in IDLE.
- Reset mid-frame during beat 4, then a new scan_start -> stream restarts at 0x10, (0,0); frame_cnt=0 then 1.

Source files
------------

// File: rtl/d8_text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d8_text_pkg
// Description : Shared constants and scan FSM encoding for the d8 text
//               memory / raster scanner block.
// Revision    : 1.0 - initial release
// ============================================================================
package d8_text_pkg;

  // Default geometry of the text plane.
  localparam int D8_ADDR_W     = 12;
  localparam int D8_DATA_W     = 8;
  localparam int D8_COLS       = 80;
  localparam int D8_ROWS       = 30;
  localparam int D8_COL_W      = 7;
  localparam int D8_ROW_W      = 5;
  localparam int D8_TEXT_CELLS = D8_COLS * D8_ROWS;

  // Scan FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_OUT  = 2'd2
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/d8_text_mem_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : d8_text_mem_scan_if
// Description : Bus bundle for the text memory block: CPU text-memory port
//               (mem_*), scan control (scan_start/scan_busy/frame_cnt) and
//               the character stream (ch_*, valid/ready).
//               slave  : view of the text memory block itself
//               master : view of the CPU / display side driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface d8_text_mem_scan_if
  import d8_text_pkg::*;
#(
  parameter int ADDR_W = D8_ADDR_W,
  parameter int DATA_W = D8_DATA_W,
  parameter int COL_W  = D8_COL_W,
  parameter int ROW_W  = D8_ROW_W
);
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_dw;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dr;
  logic              scan_start;
  logic              scan_busy;
  logic              ch_valid;
  logic              ch_ready;
  logic [DATA_W-1:0] ch_data;
  logic [COL_W-1:0]  ch_col;
  logic [ROW_W-1:0]  ch_row;
  logic              ch_last;
  logic [7:0]        frame_cnt;

  modport slave (
    input  mem_a, mem_dw, mem_we, scan_start, ch_ready,
    output mem_dr, scan_busy, ch_valid, ch_data, ch_col, ch_row, ch_last,
           frame_cnt
  );

  modport master (
    output mem_a, mem_dw, mem_we, scan_start, ch_ready,
    input  mem_dr, scan_busy, ch_valid, ch_data, ch_col, ch_row, ch_last,
           frame_cnt
  );
endinterface
`default_nettype wire

// File: rtl/d8_text_ram.sv
`default_nettype none
// ============================================================================
// Module      : d8_text_ram
// Description : 2**ADDR_W x DATA_W text RAM. Port A is CPU read/write, port B
//               is scan read-only. Both reads are registered (1-cycle latency)
//               and read-first: a same-edge write is not visible to either
//               read until the following access.
// Ports       : clk, rst_n (async, active-low; clears read registers only)
//               a_addr/a_wdata/a_we -> a_rdata
//               b_en/b_addr         -> b_rdata (holds when b_en=0)
// Revision    : 1.0 - initial release
// ============================================================================
module d8_text_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_we,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  always_comb begin
    a_rdata_d = mem[a_addr];
    b_rdata_d = b_rdata_q;
    if (b_en) b_rdata_d = mem[b_addr];
  end

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule
`default_nettype wire

// File: rtl/d8_text_mem_scan.sv
`default_nettype none
// ============================================================================
// Module      : d8_text_mem_scan
// Description : Text memory responder for the d8 core plus a raster scanner
//               that streams the visible COLS x ROWS grid to the character
//               generator, one beat per two cycles at most.
// Ports       : sys_clk  - clock
//               sys_rst  - async active-low reset
//               bus      - CPU port, scan control and character stream
// Revision    : 1.0 - initial release
// ============================================================================
module d8_text_mem_scan
  import d8_text_pkg::*;
#(
  parameter int ADDR_W = D8_ADDR_W,
  parameter int DATA_W = D8_DATA_W,
  parameter int COLS   = D8_COLS,
  parameter int ROWS   = D8_ROWS,
  parameter int COL_W  = D8_COL_W,
  parameter int ROW_W  = D8_ROW_W
) (
  input logic               sys_clk,
  input logic               sys_rst,
  d8_text_mem_scan_if.slave bus
);
  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  ch_col_q, ch_col_d;
  logic [ROW_W-1:0]  ch_row_q, ch_row_d;
  logic              ch_last_q, ch_last_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              col_end;
  logic              row_end;

  // Scan data lands in the RAM port-B register on the RD->OUT edge and is
  // held there (b_en low) for as long as the beat waits in OUT, so later
  // CPU writes cannot disturb a beat already presented.
  d8_text_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .a_addr  (bus.mem_a),
    .a_wdata (bus.mem_dw),
    .a_we    (bus.mem_we),
    .a_rdata (bus.mem_dr),
    .b_en    (state_q == ST_RD),
    .b_addr  (addr_q),
    .b_rdata (bus.ch_data)
  );

  assign col_end = (col_q == COL_W'(COLS - 1));
  assign row_end = (row_q == ROW_W'(ROWS - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    col_d       = col_q;
    row_d       = row_q;
    ch_col_d    = ch_col_q;
    ch_row_d    = ch_row_q;
    ch_last_d   = ch_last_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.scan_start) begin
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        ch_col_d  = col_q;
        ch_row_d  = row_q;
        ch_last_d = col_end && row_end;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (bus.ch_ready) begin
          if (ch_last_q) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ST_IDLE;
          end else begin
            // Linear address advances in lockstep with col/row.
            addr_d = addr_q + ADDR_W'(1);
            if (col_end) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            state_d = ST_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      ch_col_q    <= '0;
      ch_row_q    <= '0;
      ch_last_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_col_q    <= ch_col_d;
      ch_row_q    <= ch_row_d;
      ch_last_q   <= ch_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.scan_busy = (state_q != ST_IDLE);
  assign bus.ch_valid  = (state_q == ST_OUT);
  assign bus.ch_col    = ch_col_q;
  assign bus.ch_row    = ch_row_q;
  assign bus.ch_last   = ch_last_q;
  assign bus.frame_cnt = frame_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_d8_text_mem_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_d8_text_mem_scan
// Description : Directed self-checking bench for d8_text_mem_scan on a
//               4 x 2 grid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d8_text_mem_scan;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int COLS   = 4;
  localparam int ROWS   = 2;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;

  logic sys_clk;
  logic sys_rst;
  int   n_total;
  int   n_bad;
  int   exp_frames;

  d8_text_mem_scan_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) bus ();

  d8_text_mem_scan #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.mem_a  = a;
    bus.mem_dw = d;
    bus.mem_we = 1'b1;
    tick();
    bus.mem_we = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_dr"},    32'(bus.mem_dr),    32'h0);
    chk({tag, "_busy"},      32'(bus.scan_busy), 32'h0);
    chk({tag, "_valid"},     32'(bus.ch_valid),  32'h0);
    chk({tag, "_data"},      32'(bus.ch_data),   32'h0);
    chk({tag, "_col"},       32'(bus.ch_col),    32'h0);
    chk({tag, "_row"},       32'(bus.ch_row),    32'h0);
    chk({tag, "_last"},      32'(bus.ch_last),   32'h0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'h0);
  endtask

  // Runs one frame scan. Beat k (0-based) must carry 0x10+k at (k%4, k/4).
  // stall_beat/stall_len: hold ch_ready low while that beat is valid.
  // poke: pulse scan_start during beat 1 and on the last-beat acceptance.
  // abort_beat >= 0: assert reset while that beat is valid and stop there.
  task automatic scan_frame(input int stall_beat, input int stall_len,
                            input bit poke, input int abort_beat);
    int cyc;
    int beat;
    int held;
    cyc  = 0;
    beat = 0;
    held = 0;
    bus.ch_ready   = 1'b1;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(bus.scan_busy), 32'h1);
    while (bus.scan_busy && cyc < 100) begin
      bus.scan_start = 1'b0;
      if (bus.ch_valid) begin
        if (beat == abort_beat) begin
          sys_rst = 1'b0;
          #1;
          chk_all_zero("async_rst");
          exp_frames     = 0;
          bus.ch_ready   = 1'b0;
          return;
        end
        if (beat == stall_beat && held < stall_len) begin
          bus.ch_ready = 1'b0;
          chk("stall_data",  32'(bus.ch_data),  32'(8'h10 + beat));
          chk("stall_valid", 32'(bus.ch_valid), 32'h1);
          chk("stall_col",   32'(bus.ch_col),   32'(beat % COLS));
          held++;
        end else begin
          bus.ch_ready = 1'b1;
          chk("beat_data", 32'(bus.ch_data), 32'(8'h10 + beat));
          chk("beat_col",  32'(bus.ch_col),  32'(beat % COLS));
          chk("beat_row",  32'(bus.ch_row),  32'(beat / COLS));
          chk("beat_last", 32'(bus.ch_last), 32'(beat == COLS * ROWS - 1));
          if (poke && (beat == 1 || beat == COLS * ROWS - 1)) bus.scan_start = 1'b1;
          beat++;
        end
      end
      tick();
      cyc++;
    end
    bus.scan_start = 1'b0;
    chk("beat_count",  32'(beat), 32'(COLS * ROWS));
    chk("busy_cycles", 32'(cyc),  32'(2 * COLS * ROWS + 1 + stall_len));
    exp_frames = (exp_frames + 1) % 256;
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_frames));
    tick();
    chk("idle_busy",  32'(bus.scan_busy), 32'h0);
    chk("idle_valid", 32'(bus.ch_valid),  32'h0);
  endtask

  initial begin
    n_total        = 0;
    n_bad          = 0;
    exp_frames     = 0;
    bus.mem_a      = '0;
    bus.mem_dw     = '0;
    bus.mem_we     = 1'b0;
    bus.scan_start = 1'b0;
    bus.ch_ready   = 1'b0;
    sys_rst        = 1'b1;
    #1;
    sys_rst = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    chk("post_rst_busy",  32'(bus.scan_busy), 32'h0);
    chk("post_rst_frame", 32'(bus.frame_cnt), 32'h0);

    // CPU port: write then read, then read-before-write.
    cpu_write(12'h005, 8'h41);
    tick();
    chk("rd_after_wr", 32'(bus.mem_dr), 32'h41);
    bus.mem_a  = 12'h005;
    bus.mem_dw = 8'h42;
    bus.mem_we = 1'b1;
    tick();
    bus.mem_we = 1'b0;
    chk("rd_first_old", 32'(bus.mem_dr), 32'h41);
    tick();
    chk("rd_first_new", 32'(bus.mem_dr), 32'h42);

    // Scratch cell above the visible grid stays CPU-only.
    cpu_write(12'h800, 8'h5a);
    for (int i = 0; i < COLS * ROWS; i++) cpu_write(ADDR_W'(i), DATA_W'(8'h10 + i));
    bus.mem_a = 12'h800;
    tick();
    chk("scratch_rd", 32'(bus.mem_dr), 32'h5a);

    scan_frame(-1, 0, 1'b0, -1);  // full frame, ready always high
    scan_frame(2, 5, 1'b0, -1);   // backpressure on beat 3
    scan_frame(-1, 0, 1'b1, -1);  // ignored starts

    // Reset mid-frame during beat 4, then restart.
    scan_frame(-1, 0, 1'b0, 3);
    tick();
    sys_rst = 1'b1;
    tick();
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    chk("rst_busy",      32'(bus.scan_busy), 32'h0);
    scan_frame(-1, 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
